pipe_ctrl: RTL

Pipeline control and scoreboard unit for the 5-stage RV64 core (IF/ID/EX/MEM/WB). Tracks in-flight long-latency register writes (loads) and detects load-use and WAW interlocks against the instruction in ID. Sequences stall, bubble and flush per stage, and resolves memory-busy, multi-cycle-EX and taken-branch events by priority. Does not replace ID-stage EX/MEM forwarding; it covers only what forwarding cannot.

---
 rtl/pipe_ctrl_pkg.sv | 24 ++
 rtl/pipe_ctrl_if.sv | 49 ++++
 rtl/pipe_scoreboard.sv | 60 ++++++
 rtl/pipe_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the 5-stage RV64 pipeline control unit.
//   NREGS / ADDR_W : architectural integer register file geometry
//   REG_X0         : index of the hard-wired zero register (never tracked)
//   pipe_state_e   : control FSM state encoding, exported on state_o
package pipe_ctrl_pkg;

    localparam int NREGS  = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] REG_X0 = '0;

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_INTERLOCK = 3'd1,
        ST_HOLD      = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_FLUSH     = 3'd4
    } pipe_state_e;

    function automatic logic is_x0(input logic [ADDR_W-1:0] r);
        return r == REG_X0;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: bundle between the core datapath and pipe_ctrl.
//   ID instruction fields, WB retire, stage events (inputs to pipe_ctrl) and
//   per-stage stall/bubble/flush controls plus debug state (outputs).
//   master : core side (drives events, receives controls)
//   slave  : pipe_ctrl side
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic              id_valid;
    logic              id_rs1_en;
    logic              id_rs2_en;
    logic [ADDR_W-1:0] id_rs1;
    logic [ADDR_W-1:0] id_rs2;
    logic              id_rd_en;
    logic [ADDR_W-1:0] id_rd;
    logic              id_is_load;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_rd;
    logic              mem_stall;
    logic              ex_busy;
    logic              branch_taken_ex;

    logic              stall_if;
    logic              stall_id;
    logic              stall_ex;
    logic              stall_mem;
    logic              bubble_ex;
    logic              bubble_mem;
    logic              flush_if_id;
    logic              flush_id_ex;
    logic              id_issue;
    logic              stall_timeout;
    logic [2:0]        state_o;

    modport master (
        output id_valid, id_rs1_en, id_rs2_en, id_rs1, id_rs2, id_rd_en, id_rd,
               id_is_load, wb_valid, wb_rd, mem_stall, ex_busy, branch_taken_ex,
        input  stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_mem,
               flush_if_id, flush_id_ex, id_issue, stall_timeout, state_o
    );

    modport slave (
        input  id_valid, id_rs1_en, id_rs2_en, id_rs1, id_rs2, id_rd_en, id_rd,
               id_is_load, wb_valid, wb_rd, mem_stall, ex_busy, branch_taken_ex,
        output stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_mem,
               flush_if_id, flush_id_ex, id_issue, stall_timeout, state_o
    );

endinterface

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: pending-write scoreboard for long-latency (load) results.
//   set_en/set_rd   : mark set_rd pending (load issued from ID)
//   clr_en/clr_rd   : WB retires clr_rd
//   id_*            : register usage of the instruction currently in ID
//   hazard          : ID touches a register whose load has not yet written back
module pipe_scoreboard
    import pipe_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_rd,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_rd,
    input  logic              id_valid,
    input  logic              id_rs1_en,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic              id_rs2_en,
    input  logic [ADDR_W-1:0] id_rs2,
    input  logic              id_rd_en,
    input  logic [ADDR_W-1:0] id_rd,
    output logic              hazard
);

    logic [NREGS-1:1] pending_q;
    logic [NREGS-1:1] pending_d;
    logic [NREGS-1:0] clr_vec;
    logic [NREGS-1:0] eff;

    always_comb begin
        clr_vec = '0;
        if (clr_en && !is_x0(clr_rd)) begin
            clr_vec[clr_rd] = 1'b1;
        end

        // The register file is write-first, so a register retiring this
        // cycle is already readable by ID; bit 0 is always clear.
        eff    = {pending_q, 1'b0} & ~clr_vec;
        eff[0] = 1'b0;

        hazard = id_valid && ((id_rs1_en && eff[id_rs1]) ||
                              (id_rs2_en && eff[id_rs2]) ||
                              (id_rd_en  && eff[id_rd]));

        // Clear first, then set: a new load to the same register wins.
        pending_d = pending_q & ~clr_vec[NREGS-1:1];
        if (set_en && !is_x0(set_rd)) begin
            pending_d[set_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control for the IF/ID/EX/MEM/WB core.
//   clk, rst_n : core clock, asynchronous active-low reset
//   pc         : pipe_ctrl_if.slave (ID/WB/event inputs, stage controls out)
//   perf_*     : stall-cycle and flush counters, present only when the
//                PIPE_CTRL_PERF_EN macro is defined
// Priority each cycle: mem_stall > ex_busy > flush > load-use/WAW interlock.
// state_o shows the cause of the previous cycle.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STALL_TIMEOUT = 1024
`ifdef PIPE_CTRL_PERF_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic clk,
    input  logic rst_n,
    pipe_ctrl_if.slave pc
`ifdef PIPE_CTRL_PERF_EN
    , output logic [CNT_W-1:0] perf_stall_cycles
    , output logic [CNT_W-1:0] perf_flushes
`endif
);

    localparam int              WD_W   = $clog2(STALL_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(STALL_TIMEOUT);

    pipe_state_e     state_q, state_d;
    logic            flush_pend_q, flush_pend_d;
    logic            br_prev_q, br_prev_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;

    logic hazard;
    logic set_load;
    logic branch_new;
    logic flush_now;
    logic s_if, s_id, s_ex, s_mem, b_ex, b_mem, f_if_id, f_id_ex, issue;
    logic stalled;

    pipe_scoreboard u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en    (set_load),
        .set_rd    (pc.id_rd),
        .clr_en    (pc.wb_valid),
        .clr_rd    (pc.wb_rd),
        .id_valid  (pc.id_valid),
        .id_rs1_en (pc.id_rs1_en),
        .id_rs1    (pc.id_rs1),
        .id_rs2_en (pc.id_rs2_en),
        .id_rs2    (pc.id_rs2),
        .id_rd_en  (pc.id_rd_en),
        .id_rd     (pc.id_rd),
        .hazard    (hazard)
    );

    always_comb begin
        s_if         = 1'b0;
        s_id         = 1'b0;
        s_ex         = 1'b0;
        s_mem        = 1'b0;
        b_ex         = 1'b0;
        b_mem        = 1'b0;
        f_if_id      = 1'b0;
        f_id_ex      = 1'b0;
        state_d      = ST_RUN;
        flush_pend_d = flush_pend_q;
        br_prev_d    = pc.branch_taken_ex;

        // A branch held high across several cycles is one event: only its
        // first cycle counts, so it is flushed exactly once.
        branch_new = pc.branch_taken_ex && !br_prev_q;
        flush_now  = branch_new || flush_pend_q;

        if (pc.mem_stall) begin
            {s_if, s_id, s_ex, s_mem} = 4'b1111;
            state_d      = ST_DRAIN;
            flush_pend_d = flush_pend_q || branch_new;
        end else if (pc.ex_busy) begin
            {s_if, s_id, s_ex} = 3'b111;
            b_mem        = 1'b1;
            state_d      = ST_HOLD;
            flush_pend_d = flush_pend_q || branch_new;
        end else if (flush_now) begin
            f_if_id      = 1'b1;
            f_id_ex      = 1'b1;
            state_d      = ST_FLUSH;
            flush_pend_d = 1'b0;
        end else if (hazard) begin
            s_if    = 1'b1;
            s_id    = 1'b1;
            b_ex    = 1'b1;
            state_d = ST_INTERLOCK;
        end

        // Outputs are held low while reset is asserted.
        if (!rst_n) begin
            {s_if, s_id, s_ex, s_mem, b_ex, b_mem, f_if_id, f_id_ex} = '0;
        end

        issue    = rst_n && pc.id_valid && !s_id && !f_id_ex;
        set_load = issue && pc.id_rd_en && pc.id_is_load;

        stalled = (state_d == ST_DRAIN) || (state_d == ST_HOLD) ||
                  (state_d == ST_INTERLOCK);
        if (!stalled) begin
            wd_d = '0;
        end else if (wd_q == WD_MAX) begin
            wd_d = wd_q;
        end else begin
            wd_d = wd_q + 1'b1;
        end
        timeout_d = timeout_q || (wd_d == WD_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            flush_pend_q <= 1'b0;
            br_prev_q    <= 1'b0;
            wd_q         <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            br_prev_q    <= br_prev_d;
            wd_q         <= wd_d;
            timeout_q    <= timeout_d;
        end
    end

    assign pc.stall_if      = s_if;
    assign pc.stall_id      = s_id;
    assign pc.stall_ex      = s_ex;
    assign pc.stall_mem     = s_mem;
    assign pc.bubble_ex     = b_ex;
    assign pc.bubble_mem    = b_mem;
    assign pc.flush_if_id   = f_if_id;
    assign pc.flush_id_ex   = f_id_ex;
    assign pc.id_issue      = issue;
    assign pc.stall_timeout = timeout_q;
    assign pc.state_o       = state_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + CNT_W'(s_if | s_id | s_ex | s_mem);
        flush_cnt_d = flush_cnt_q + CNT_W'(f_id_ex);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cycles = stall_cnt_q;
    assign perf_flushes      = flush_cnt_q;
`endif

endmodule
